shift_unit: RTL and testbench
=============================

# shift_unit

Multi-cycle barrel-free shifter on the datapath side of the multicycle CPU, downstream of the control unit. Control asserts `Start` with a shift operation, operand and shift amount. The block shifts one bit position per clock and pulses `Done` when the result is stable. Control holds its shift-wait state until `Done`, then writes `DataOut` back to the register file.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits
- `SHAMT_W`, 5, shift-amount width; must satisfy 2^SHAMT_W == WIDTH

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  request; sampled only in IDLE
- `ShiftOp`  in  2  0=SLL, 1=SRL, 2=SRA, 3=ROR (rotate right)
- `DataIn`  in  WIDTH  operand; captured on accepted Start
- `Shamt`  in  SHAMT_W  shift amount, 0..WIDTH-1; captured on accepted Start
- `DataOut`  out  WIDTH  shift register contents; final result when Done=1
- `Busy`  out  1  high in every state except IDLE
- `Done`  out  1  one-cycle result-valid pulse
- `StateAux`  out  2  current state encoding, for debug (IDLE=0, SHIFT=1, DONE=2)

## Operation
- Internal registers:
  - `ShReg[WIDTH]`, drives DataOut
  - `Count[SHAMT_W]`
  - `OpReg[2]`
  - 2-bit state
- Reset (Reset=0, asynchronous):
  - state=IDLE, ShReg=0, Count=0, OpReg=0
  - Busy=0, Done=0, DataOut=0, StateAux=0
  - Any operation in progress is abandoned. No Done is issued for it.
- IDLE:
  - If Start=1, on the edge: ShReg<=DataIn, Count<=Shamt, OpReg<=ShiftOp.
  - Next state: SHIFT if Shamt!=0, else DONE.
  - If Start=0, all registers hold.
- SHIFT, one step per edge:
  - SLL: ShReg<={ShReg[W-2:0],0}
  - SRL: ShReg<={0,ShReg[W-1:1]}
  - SRA: ShReg<={ShReg[W-1],ShReg[W-1:1]}
  - ROR: ShReg<={ShReg[0],ShReg[W-1:1]}
  - Count<=Count-1 on each step.
  - When Count==1 at the edge, perform the final step and go to DONE.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle, then go to IDLE unconditionally.
  - Start is ignored while in DONE.
- DataOut holds the last result through IDLE until the next accepted Start overwrites ShReg.
- Start in SHIFT or DONE is ignored. It is not queued, and DataIn/Shamt/ShiftOp changes are not observed.
- Done and Busy are registered state decodes, not combinational functions of the inputs.
- Shamt carries no out-of-range value because its width fixes the range. Count never underflows.

## Timing
- Latency from the accepting edge (Start=1 in IDLE) to the first cycle with Done=1:
  - Shamt+1 edges
  - Shamt=0: Done on the cycle after acceptance, DataOut=DataIn
  - Shamt=31: 32 edges
- Busy rises on the accepting edge. It falls on the edge that leaves DONE.
- Minimum repeat: a new Start is accepted on the first edge with state=IDLE, i.e. the edge after Done drops. Back-to-back throughput is Shamt+2 cycles per operation.
- Inputs must be stable around the rising edge. Control drives on the falling edge, giving half a cycle of setup.
- A Reset assertion in any state forces the reset values immediately, without waiting for a clock. Deassertion takes effect at the next rising edge, and the block starts in IDLE.

## Test plan
- Reset: hold Reset=0 mid-SHIFT (SLL, Shamt=10, after 4 steps) -> DataOut=0, Busy=0, Done=0, StateAux=0 without a clock edge. After release, no Done ever appears for the abandoned operation.
- SLL: DataIn=32'h0000_00F1, Shamt=4, ShiftOp=0 -> Done exactly 5 edges after acceptance, DataOut=32'h0000_0F10, Busy high for 5 cycles.
- SRA vs SRL: DataIn=32'h8000_0010, Shamt=4:
  - SRA -> DataOut=32'hF800_0001
  - SRL -> DataOut=32'h0800_0001
- ROR and extremes:
  - DataIn=32'h0000_0001, Shamt=31, ShiftOp=3 -> DataOut=32'h0000_0002 after 32 edges
  - Shamt=0 with DataIn=32'hDEAD_BEEF -> Done one edge later, DataOut=32'hDEAD_BEEF
- Start during Busy: Start=1 with new DataIn=32'h1234_5678 held for every cycle of a Shamt=3 SLL of 32'h1 -> DataOut=32'h0000_0008. The held Start is accepted on the first IDLE edge, and Done pulses once per operation.
- Back-to-back: two operations (Shamt=1, then Shamt=2) with Start asserted the cycle after the first Done:
  - Done pulses are separated by exactly 4 cycles.
  - DataOut holds the first result between operations.

Source files
------------

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle one-bit-per-clock shifter (SLL/SRL/SRA/ROR)
//
// Ports:
//   clk      in   system clock, rising edge
//   Reset    in   asynchronous active-low reset
//   Start    in   operation request, sampled only in IDLE
//   ShiftOp  in   [1:0] 0=SLL 1=SRL 2=SRA 3=ROR
//   DataIn   in   [WIDTH-1:0] operand, captured on accepted Start
//   Shamt    in   [SHAMT_W-1:0] shift amount, captured on accepted Start
//   DataOut  out  [WIDTH-1:0] shift register, final result while Done=1
//   Busy     out  high in every state except IDLE
//   Done     out  one-cycle result-valid pulse
//   StateAux out  [1:0] current state (IDLE=0 SHIFT=1 DONE=2)

module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [1:0]         ShiftOp,
    input  logic [WIDTH-1:0]   DataIn,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [WIDTH-1:0]   DataOut,
    output logic               Busy,
    output logic               Done,
    output logic [1:0]         StateAux
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [WIDTH-1:0]   shReg;
    logic [WIDTH-1:0]   shNext;
    logic [WIDTH-1:0]   shStep;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] countNext;
    logic [1:0]         opReg;
    logic [1:0]         opNext;

    // One-position step of the latched operation; the operation is taken
    // from opReg so ShiftOp changes mid-operation have no effect.
    always_comb begin
        shStep = shReg;
        case (opReg)
            2'd0:    shStep = {shReg[WIDTH-2:0], 1'b0};
            2'd1:    shStep = {1'b0, shReg[WIDTH-1:1]};
            2'd2:    shStep = {shReg[WIDTH-1], shReg[WIDTH-1:1]};
            default: shStep = {shReg[0], shReg[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        nextState = state;
        shNext    = shReg;
        countNext = count;
        opNext    = opReg;
        case (state)
            IDLE: begin
                if (Start) begin
                    shNext    = DataIn;
                    countNext = Shamt;
                    opNext    = ShiftOp;
                    nextState = (Shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                shNext    = shStep;
                countNext = count - SHAMT_W'(1);
                // Count==1 means this edge performs the last step.
                if (count == SHAMT_W'(1)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            shReg <= '0;
            count <= '0;
            opReg <= 2'd0;
        end else begin
            state <= nextState;
            shReg <= shNext;
            count <= countNext;
            opReg <= opNext;
        end
    end

    // Pure decodes of registered state, so no input reaches these outputs.
    assign DataOut  = shReg;
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);
    assign StateAux = state;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed self-checking bench for shift_unit

module tb_shift_unit;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  ShiftOp;
    logic [31:0] DataIn;
    logic [4:0]  Shamt;
    logic [31:0] DataOut;
    logic        Busy;
    logic        Done;
    logic [1:0]  StateAux;

    int errors = 0;
    int checks = 0;

    shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Start    (Start),
        .ShiftOp  (ShiftOp),
        .DataIn   (DataIn),
        .Shamt    (Shamt),
        .DataOut  (DataOut),
        .Busy     (Busy),
        .Done     (Done),
        .StateAux (StateAux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request for a single cycle; returns at the negedge just after
    // the accepting rising edge.
    task automatic startOp(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        @(negedge clk);
        Start   = 1'b1;
        DataIn  = d;
        Shamt   = s;
        ShiftOp = op;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Runs one operation and checks latency (edges from acceptance to the
    // first Done cycle) and the final result.
    task automatic runOp(input string name, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] op, input logic [31:0] expData);
        int edges;
        edges = 1;
        startOp(d, s, op);
        while (!Done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges !== s + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, s + 1);
        end
        checks++;
        if (DataOut !== expData) begin
            errors++;
            $display("FAIL %s data: got %h, expected %h", name, DataOut, expData);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        int doneSeen;
        Reset   = 1'b0;
        Start   = 1'b0;
        ShiftOp = 2'd0;
        DataIn  = '0;
        Shamt   = '0;
        #12;
        checks++;
        if ({DataOut, Busy, Done, StateAux} !== 36'h0) begin
            errors++;
            $display("FAIL reset_values: got DataOut=%h Busy=%b Done=%b StateAux=%0d, expected all 0",
                     DataOut, Busy, Done, StateAux);
        end
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);

        // Mid-SHIFT asynchronous reset: SLL by 10, after 4 steps.
        startOp(32'h0000_FFFF, 5'd10, 2'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (DataOut !== 32'h000F_FFF0) begin
            errors++;
            $display("FAIL reset_presteps: got %h, expected %h", DataOut, 32'h000F_FFF0);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({DataOut, Busy, Done, StateAux} !== 36'h0) begin
            errors++;
            $display("FAIL reset_async: got DataOut=%h Busy=%b Done=%b StateAux=%0d, expected all 0",
                     DataOut, Busy, Done, StateAux);
        end
        @(negedge clk);
        Reset = 1'b1;
        doneSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (Done) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0 || StateAux !== 2'd0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d Done pulses state=%0d, expected 0 and 0",
                     doneSeen, StateAux);
        end
    endtask

    task automatic test_sll;
        int busyCycles;
        int edges;
        busyCycles = 0;
        edges = 1;
        startOp(32'h0000_00F1, 5'd4, 2'd0);
        checks++;
        if (StateAux !== 2'd1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL sll_accept: got state=%0d Busy=%b, expected 1 and 1", StateAux, Busy);
        end
        while (!Done && edges < 100) begin
            if (Busy) busyCycles++;
            @(negedge clk);
            edges++;
        end
        if (Busy) busyCycles++;
        checks++;
        if (edges !== 5) begin
            errors++;
            $display("FAIL sll_latency: got %0d, expected 5", edges);
        end
        checks++;
        if (DataOut !== 32'h0000_0F10) begin
            errors++;
            $display("FAIL sll_data: got %h, expected %h", DataOut, 32'h0000_0F10);
        end
        checks++;
        if (busyCycles !== 5) begin
            errors++;
            $display("FAIL sll_busy: got %0d cycles, expected 5", busyCycles);
        end
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || DataOut !== 32'h0000_0F10) begin
            errors++;
            $display("FAIL sll_idle_hold: got Busy=%b Done=%b DataOut=%h, expected 0 0 %h",
                     Busy, Done, DataOut, 32'h0000_0F10);
        end
    endtask

    task automatic test_sra_srl;
        runOp("sra", 32'h8000_0010, 5'd4, 2'd2, 32'hF800_0001);
        runOp("srl", 32'h8000_0010, 5'd4, 2'd1, 32'h0800_0001);
    endtask

    task automatic test_extremes;
        runOp("ror31", 32'h0000_0001, 5'd31, 2'd3, 32'h0000_0002);
        runOp("shamt0", 32'hDEAD_BEEF, 5'd0, 2'd0, 32'hDEAD_BEEF);
        runOp("ror4", 32'h1234_5678, 5'd4, 2'd3, 32'h8123_4567);
    endtask

    task automatic test_start_busy;
        int doneCount;
        int edges;
        doneCount = 0;
        edges = 1;
        startOp(32'h0000_0001, 5'd3, 2'd0);
        Start  = 1'b1;
        DataIn = 32'h1234_5678;
        while (!Done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        doneCount++;
        checks++;
        if (DataOut !== 32'h0000_0008 || edges !== 4) begin
            errors++;
            $display("FAIL busy_first: got %h after %0d edges, expected %h after 4",
                     DataOut, edges, 32'h0000_0008);
        end
        @(negedge clk);
        checks++;
        if (StateAux !== 2'd0 || DataOut !== 32'h0000_0008) begin
            errors++;
            $display("FAIL busy_idle: got state=%0d DataOut=%h, expected 0 %h",
                     StateAux, DataOut, 32'h0000_0008);
        end
        @(negedge clk);
        Start = 1'b0;
        checks++;
        if (StateAux !== 2'd1 || DataOut !== 32'h1234_5678) begin
            errors++;
            $display("FAIL busy_accept: got state=%0d DataOut=%h, expected 1 %h",
                     StateAux, DataOut, 32'h1234_5678);
        end
        repeat (10) begin
            @(negedge clk);
            if (Done) doneCount++;
        end
        checks++;
        if (doneCount !== 2 || DataOut !== 32'h91A2_B3C0) begin
            errors++;
            $display("FAIL busy_second: got %0d Done pulses DataOut=%h, expected 2 %h",
                     doneCount, DataOut, 32'h91A2_B3C0);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        startOp(32'h0000_0003, 5'd1, 2'd0);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got Done=%b, expected 0", Done);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b1 || DataOut !== 32'h0000_0006) begin
            errors++;
            $display("FAIL b2b_first: got Done=%b DataOut=%h, expected 1 %h",
                     Done, DataOut, 32'h0000_0006);
        end
        gap = 0;
        @(negedge clk);
        gap++;
        Start   = 1'b1;
        DataIn  = 32'h0000_0005;
        Shamt   = 5'd2;
        ShiftOp = 2'd0;
        checks++;
        if (DataOut !== 32'h0000_0006 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got DataOut=%h Busy=%b, expected %h 0",
                     DataOut, Busy, 32'h0000_0006);
        end
        @(negedge clk);
        gap++;
        Start = 1'b0;
        while (!Done && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap !== 4 || DataOut !== 32'h0000_0014) begin
            errors++;
            $display("FAIL b2b_second: got gap=%0d DataOut=%h, expected 4 %h",
                     gap, DataOut, 32'h0000_0014);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_extremes();
        test_start_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
